// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
//   Types and helpers shared by the bus arbiter and its priority picker.
//   arb_state_t : arbiter ownership state (no owner / one owner)
//   clog2_min1  : index width helper, never returns less than one bit
// -----------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  function automatic int clog2_min1(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
//   Combinational rotating-priority search. Starting at ptr (or at index 0
//   when rr_mode is low) it scans upward with wrap and returns the first set
//   request bit.
//   req     in   N    request vector
//   ptr     in   IW   first index to consider in rotating mode
//   rr_mode in   1    1 = rotate from ptr, 0 = fixed priority from index 0
//   found   out  1    at least one request is set
//   idx     out  IW   index of the winning request (0 when none)
// -----------------------------------------------------------------------------
module arb_pick
  import arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          rr_mode,
  output logic          found,
  output logic [IW-1:0] idx
);

  int start;
  int cand;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    start = rr_mode ? int'(ptr) : 0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      // start < N, so a single subtraction is enough to wrap
      cand = start + i;
      if (cand >= N) cand = cand - N;
      if (req[cand[IW-1:0]]) begin
        found = 1'b1;
        idx   = cand[IW-1:0];
        break;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   N-master bus arbiter with fixed-priority or round-robin selection,
//   bounded grant tenure with preemption, and owner lock against preemption.
//   clk       in   1           bus clock
//   reset_n   in   1           asynchronous active-low reset
//   m_req     in   N_MASTERS   per-master request (level)
//   m_lock    in   N_MASTERS   per-master lock, honoured only for the owner
//   m_gnt     out  N_MASTERS   registered one-hot-or-zero grant
//   gnt_valid out  1           registered |m_gnt
//   gnt_idx   out  IW          registered owner index, 0 when no grant
//   preempt   out  1           one-cycle pulse when a tenure timeout revokes a grant
// -----------------------------------------------------------------------------
module bus_arbiter_rr
  import arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int RR_MODE   = 1,
  parameter int MAX_HOLD  = 16
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [N_MASTERS-1:0]                m_req,
  input  logic [N_MASTERS-1:0]                m_lock,
  output logic [N_MASTERS-1:0]                m_gnt,
  output logic                                gnt_valid,
  output logic [clog2_min1(N_MASTERS)-1:0]    gnt_idx,
  output logic                                preempt
);

  localparam int IW = clog2_min1(N_MASTERS);
  localparam int HW = clog2_min1(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : HW'(MAX_HOLD - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_MASTERS - 1);

  arb_state_t           state, state_nxt;
  logic [N_MASTERS-1:0] gnt_nxt;
  logic                 valid_nxt;
  logic [IW-1:0]        idx_nxt;
  logic [IW-1:0]        rr_ptr, ptr_nxt;
  logic [HW-1:0]        hold_cnt, hold_nxt;
  logic                 pre_nxt;

  logic                 pick_found;
  logic [IW-1:0]        pick_idx;
  logic                 owner_req;
  logic                 owner_lock;
  logic                 others_req;
  logic                 timeout;

  arb_pick #(.N(N_MASTERS), .IW(IW)) u_pick (
    .req     (m_req),
    .ptr     (rr_ptr),
    .rr_mode (RR_MODE != 0),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  assign owner_req  = m_req[gnt_idx];
  assign owner_lock = m_lock[gnt_idx];
  assign others_req = |(m_req & ~m_gnt);
  // hold_cnt only climbs to HOLD_SAT, so "last or saturated" means the tenure is spent;
  // the saturated case covers a lock that outlived the timeout
  assign timeout    = (MAX_HOLD != 0) &&
                      ((hold_cnt == HOLD_LAST) || (hold_cnt == HOLD_SAT));

  always_comb begin
    state_nxt = state;
    gnt_nxt   = m_gnt;
    valid_nxt = gnt_valid;
    idx_nxt   = gnt_idx;
    ptr_nxt   = rr_ptr;
    hold_nxt  = hold_cnt;
    pre_nxt   = 1'b0;
    case (state)
      ARB_IDLE: begin
        gnt_nxt   = '0;
        valid_nxt = 1'b0;
        idx_nxt   = '0;
        hold_nxt  = '0;
        if (pick_found) begin
          state_nxt         = ARB_GRANT;
          gnt_nxt[pick_idx] = 1'b1;
          valid_nxt         = 1'b1;
          idx_nxt           = pick_idx;
          if (RR_MODE != 0)
            ptr_nxt = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        end
      end
      ARB_GRANT: begin
        if (!owner_req || (timeout && others_req && !owner_lock)) begin
          // a plain release wins over a simultaneous timeout: no preempt pulse
          state_nxt = ARB_IDLE;
          gnt_nxt   = '0;
          valid_nxt = 1'b0;
          idx_nxt   = '0;
          hold_nxt  = '0;
          pre_nxt   = owner_req;
        end else if (hold_cnt != HOLD_SAT) begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ARB_IDLE;
      m_gnt     <= '0;
      gnt_valid <= 1'b0;
      gnt_idx   <= '0;
      rr_ptr    <= '0;
      hold_cnt  <= '0;
      preempt   <= 1'b0;
    end else begin
      state     <= state_nxt;
      m_gnt     <= gnt_nxt;
      gnt_valid <= valid_nxt;
      gnt_idx   <= idx_nxt;
      rr_ptr    <= ptr_nxt;
      hold_cnt  <= hold_nxt;
      preempt   <= pre_nxt;
    end
  end

endmodule
